// File: rtl/msx_slot_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : msx_slot_io_bridge
// Purpose  : Turns asynchronous Z80 slot I/O cycles aimed at the 4-port VDP
//            window into single-request transactions on the internal VDP bus.
//            Synchronises the strobes, buffers one write, and steers the
//            slot data bus for reads. Requests WAIT while the VDP is busy.
// Revision : 1.0 - initial release
// ============================================================================
module msx_slot_io_bridge #(
  parameter logic [7:0] IO_BASE     = 8'h88,  // bits [1:0] must be zero
  parameter int         SYNC_STAGES = 2       // 2 or 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_busy,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  output logic       slot_wait,
  output logic [1:0] bus_address,
  output logic       bus_write,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_HOLD = 3'd3;
  localparam logic [2:0] ST_END     = 3'd4;

  // Strobe synchronisers; the last stage is the clean, active-low view.
  logic [SYNC_STAGES-1:0] iorq_sync_q;
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic s_iorq, s_rd, s_wr;

  // Previous-cycle activity, used for falling-edge (start) detection.
  logic wr_act_q, rd_act_q;

  logic [2:0] state_q, state_d;
  logic       bus_valid_q, bus_valid_d;
  logic       bus_write_q, bus_write_d;
  logic [1:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;
  logic [7:0] d_out_q, d_out_d;
  logic       dir_q, dir_d;

  // One-deep queue for a start that arrives while a write is outstanding.
  logic       pend_q, pend_d;
  logic       pend_wr_q, pend_wr_d;
  logic [1:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_data_q, pend_data_d;

  logic       w_wr_act, w_rd_act;
  logic       w_wr_start, w_rd_start, w_hit, w_hit_start;
  logic       w_accept;
  logic       w_next_pend, w_next_wr;
  logic [1:0] w_next_addr;
  logic [7:0] w_next_data;

  // Shift the raw strobes through the synchroniser chains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iorq_sync_q <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      wr_act_q    <= 1'b0;
      rd_act_q    <= 1'b0;
    end else begin
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], slot_iorq_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], slot_rd_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], slot_wr_n};
      wr_act_q    <= w_wr_act;
      rd_act_q    <= w_rd_act;
    end
  end

  assign s_iorq = iorq_sync_q[SYNC_STAGES-1];
  assign s_rd   = rd_sync_q[SYNC_STAGES-1];
  assign s_wr   = wr_sync_q[SYNC_STAGES-1];

  // Write wins when both strobes are low, so a read start is masked then.
  assign w_wr_act    = ~s_iorq & ~s_wr;
  assign w_rd_act    = ~s_iorq & ~s_rd;
  assign w_wr_start  = w_wr_act & ~wr_act_q;
  assign w_rd_start  = w_rd_act & ~rd_act_q & ~w_wr_act;
  assign w_hit       = (slot_a[7:2] == IO_BASE[7:2]);
  assign w_hit_start = (w_wr_start | w_rd_start) & w_hit;
  assign w_accept    = bus_valid_q & bus_ready;

  // Request to issue after the outstanding write: a queued one, or one
  // starting in the very cycle the write is accepted.
  assign w_next_pend = pend_q | w_hit_start;
  assign w_next_wr   = pend_q ? pend_wr_q   : w_wr_start;
  assign w_next_addr = pend_q ? pend_addr_q : slot_a[1:0];
  assign w_next_data = pend_q ? pend_data_q : slot_d_in;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= 2'd0;
      bus_wdata_q <= 8'd0;
      d_out_q     <= 8'd0;
      dir_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= 2'd0;
      pend_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      d_out_q     <= d_out_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_hit_start) state_d = w_wr_start ? ST_WR_REQ : ST_RD_WAIT;
      end
      ST_WR_REQ: begin
        if (w_accept) begin
          if (w_next_pend) state_d = w_next_wr ? ST_WR_REQ : ST_RD_WAIT;
          else             state_d = ST_END;
        end
      end
      ST_RD_WAIT: begin
        if (bus_rdata_en) state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (s_rd | s_iorq) state_d = ST_IDLE;
      end
      ST_END: begin
        if (s_iorq & s_wr & s_rd) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates that accompany each transition.
  always_comb begin
    bus_valid_d = bus_valid_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    d_out_d     = d_out_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    case (state_q)
      ST_IDLE: begin
        if (w_hit_start) begin
          bus_valid_d = 1'b1;
          bus_write_d = w_wr_start;
          bus_addr_d  = slot_a[1:0];
          if (w_wr_start) bus_wdata_d = slot_d_in;
        end
      end
      ST_WR_REQ: begin
        if (w_accept) begin
          if (w_next_pend) begin
            bus_valid_d = 1'b1;
            bus_write_d = w_next_wr;
            bus_addr_d  = w_next_addr;
            if (w_next_wr) bus_wdata_d = w_next_data;
            pend_d      = 1'b0;
          end else begin
            bus_valid_d = 1'b0;
          end
        end else if (w_hit_start && !pend_q) begin
          pend_d      = 1'b1;
          pend_wr_d   = w_wr_start;
          pend_addr_d = slot_a[1:0];
          pend_data_d = slot_d_in;
        end
      end
      ST_RD_WAIT: begin
        if (w_accept) bus_valid_d = 1'b0;
        if (bus_rdata_en) begin
          d_out_d     = bus_rdata;
          dir_d       = 1'b1;
          bus_valid_d = 1'b0;
        end
      end
      ST_RD_HOLD: begin
        if (s_rd | s_iorq) dir_d = 1'b0;
      end
      default: ;
    endcase
  end

  // WAIT to the CPU: during reset/init, while a read is outstanding, or
  // while a second access is queued behind an unaccepted write.
  always_comb begin
    slot_wait = reset | init_busy | (state_q == ST_RD_WAIT) |
                ((state_q == ST_WR_REQ) & pend_q);
  end

  assign slot_d_out    = d_out_q;
  assign slot_data_dir = dir_q;
  assign bus_address   = bus_addr_q;
  assign bus_write     = bus_write_q;
  assign bus_valid     = bus_valid_q;
  assign bus_wdata     = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_io_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_msx_slot_io_bridge
// Purpose  : Self-checking bench: Z80 I/O cycle driver, VDP responder,
//            transaction log compared against an expected-transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msx_slot_io_bridge;

  localparam logic [7:0] IO_BASE     = 8'h88;
  localparam int         SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset, init_busy;
  logic [7:0] slot_a, slot_d_in, slot_d_out;
  logic       slot_data_dir, slot_iorq_n, slot_rd_n, slot_wr_n, slot_wait;
  logic [1:0] bus_address;
  logic       bus_write, bus_valid, bus_ready, bus_rdata_en;
  logic [7:0] bus_wdata, bus_rdata;

  msx_slot_io_bridge #(.IO_BASE(IO_BASE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
    .slot_data_dir(slot_data_dir), .slot_iorq_n(slot_iorq_n),
    .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n), .slot_wait(slot_wait),
    .bus_address(bus_address), .bus_write(bus_write), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rdata_en(bus_rdata_en)
  );

  always #6 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    int         rdy;
    int         rdd;
    bit         exp_hit;
    logic [1:0] exp_addr;
  } vec_t;

  txn_t obs_q[$];
  txn_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ready_delay = 0;
  int   rdata_delay = 0;
  logic [7:0] rdata_val = 8'h00;
  bit   vdp_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // VDP responder: raises ready after ready_delay cycles of valid, logs each
  // accepted request, and returns read data rdata_delay cycles after accept.
  initial begin : vdp
    int   vcnt;
    int   rcnt;
    txn_t t;
    vcnt = 0; rcnt = 0;
    bus_ready = 1'b0; bus_rdata_en = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_rdata_en = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin bus_rdata = rdata_val; bus_rdata_en = 1'b1; end
      end
      if (reset) begin
        bus_ready = 1'b0; vcnt = 0; rcnt = 0; bus_rdata_en = 1'b0;
      end else if (bus_ready) begin
        bus_ready = 1'b0; vcnt = 0;
      end else if (bus_valid && !vdp_hold) begin
        if (vcnt >= ready_delay) begin
          bus_ready = 1'b1;
          t.wr = bus_write; t.addr = bus_address;
          t.data = bus_write ? bus_wdata : rdata_val;
          obs_q.push_back(t);
          if (!bus_write) begin
            if (rdata_delay == 0) begin bus_rdata = rdata_val; bus_rdata_en = 1'b1; end
            else rcnt = rdata_delay;
          end
        end else begin
          vcnt++;
        end
      end
    end
  end

  // One Z80 IN/OUT cycle; stretched while slot_wait is high.
  task automatic z80_io(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd_val, output bit dir_seen,
                        output bit waited, output bit timeout, output int rel_cycles);
    int cnt;
    @(negedge clk);
    slot_a = a; slot_d_in = d;
    @(negedge clk);
    slot_iorq_n = 1'b0;
    if (wr) slot_wr_n = 1'b0; else slot_rd_n = 1'b0;
    waited = 1'b0; timeout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (slot_wait) waited = 1'b1;
    end
    cnt = 0;
    while (slot_wait && cnt < 3000) begin
      waited = 1'b1;
      @(negedge clk);
      cnt++;
    end
    if (slot_wait) timeout = 1'b1;
    rd_val = slot_d_out; dir_seen = slot_data_dir;
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
    rel_cycles = 0;
    if (!wr && dir_seen) begin
      while (slot_data_dir && rel_cycles < 20) begin
        @(negedge clk);
        rel_cycles++;
      end
    end
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while ((bus_valid || slot_wait) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_drain"}, {31'd0, bus_valid | slot_wait}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Reference rule: an access is for the VDP when its port lies in
  // [IO_BASE, IO_BASE+3]; a hit read returns whatever the VDP supplies.
  task automatic run_op(input string name, input bit wr, input logic [7:0] a,
                        input logic [7:0] d);
    bit hit, dir_seen, waited, tmo;
    logic [7:0] rv;
    int rel;
    txn_t t;
    hit = (int'(a) >= int'(IO_BASE)) && (int'(a) < int'(IO_BASE) + 4);
    if (!wr) rdata_val = d;
    z80_io(wr, a, d, rv, dir_seen, waited, tmo, rel);
    check({name, "_timeout"}, {31'd0, tmo}, 32'd0);
    if (hit) begin
      t.wr = wr; t.addr = 2'(int'(a) - int'(IO_BASE)); t.data = d;
      exp_q.push_back(t);
    end else begin
      check({name, "_miss_wait"}, {31'd0, waited}, 32'd0);
    end
    if (!wr) begin
      if (hit) begin
        check({name, "_rdata"}, {24'd0, rv}, {24'd0, d});
        check({name, "_dir"}, {31'd0, dir_seen}, 32'd1);
        check({name, "_dir_release"}, {31'd0, rel <= SYNC_STAGES + 2}, 32'd1);
      end else begin
        check({name, "_miss_dir"}, {31'd0, dir_seen}, 32'd0);
      end
    end
  endtask

  task automatic compare_logs(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({name, "_txn"}, {21'd0, obs_q[i]}, {21'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[8];
    logic [7:0] rv, a;
    bit  dir_seen, w1, w2, tmo, bad;
    int  rel, sz0, cnt;

    vecs[0] = '{1'b1, 8'h88, 8'h5A, 0, 0, 1'b1, 2'd0};
    vecs[1] = '{1'b1, 8'h8B, 8'hFF, 3, 0, 1'b1, 2'd3};
    vecs[2] = '{1'b0, 8'h89, 8'hA5, 0, 10, 1'b1, 2'd1};
    vecs[3] = '{1'b0, 8'h8A, 8'h3C, 2, 0, 1'b1, 2'd2};
    vecs[4] = '{1'b1, 8'h98, 8'h11, 0, 0, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 8'h8C, 8'h77, 0, 0, 1'b0, 2'd0};
    vecs[6] = '{1'b1, 8'h87, 8'h22, 0, 0, 1'b0, 2'd0};
    vecs[7] = '{1'b0, 8'h8B, 8'h0F, 5, 3, 1'b1, 2'd3};

    reset = 1'b1; init_busy = 1'b1;
    slot_a = 8'h00; slot_d_in = 8'h00;
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_wait", {31'd0, slot_wait}, 32'd1);
    check("rst_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_write", {31'd0, bus_write}, 32'd0);
    check("rst_addr", {30'd0, bus_address}, 32'd0);
    check("rst_wdata", {24'd0, bus_wdata}, 32'd0);
    check("rst_dout", {24'd0, slot_d_out}, 32'd0);
    check("rst_dir", {31'd0, slot_data_dir}, 32'd0);

    // Initialisation window: WAIT held, no bus traffic.
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!slot_wait || bus_valid) bad = 1'b1;
    end
    check("init_window", {31'd0, bad}, 32'd0);
    init_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("init_release_wait", {31'd0, slot_wait}, 32'd0);

    // Table-driven single accesses.
    for (int v = 0; v < 8; v++) begin
      ready_delay = vecs[v].rdy; rdata_delay = vecs[v].rdd;
      sz0 = obs_q.size();
      run_op($sformatf("vec%0d", v), vecs[v].wr, vecs[v].a, vecs[v].d);
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_pulses", v), obs_q.size() - sz0, vecs[v].exp_hit ? 1 : 0);
      if (vecs[v].exp_hit && obs_q.size() > sz0) begin
        check($sformatf("vec%0d_bwrite", v), {31'd0, obs_q[sz0].wr}, {31'd0, vecs[v].wr});
        check($sformatf("vec%0d_baddr", v), {30'd0, obs_q[sz0].addr}, {30'd0, vecs[v].exp_addr});
        if (vecs[v].wr)
          check($sformatf("vec%0d_bwdata", v), {24'd0, obs_q[sz0].data}, {24'd0, vecs[v].d});
      end
    end
    compare_logs("table");

    // Back-to-back writes while the VDP stalls for 40 cycles.
    ready_delay = 40; rdata_delay = 0;
    z80_io(1'b1, 8'h89, 8'h80, rv, dir_seen, w1, tmo, rel);
    check("b2b_first_timeout", {31'd0, tmo}, 32'd0);
    z80_io(1'b1, 8'h89, 8'h43, rv, dir_seen, w2, tmo, rel);
    check("b2b_second_timeout", {31'd0, tmo}, 32'd0);
    check("b2b_first_wait", {31'd0, w1}, 32'd0);
    check("b2b_second_wait", {31'd0, w2}, 32'd1);
    drain("b2b");
    exp_q.push_back('{1'b1, 2'd1, 8'h80});
    exp_q.push_back('{1'b1, 2'd1, 8'h43});
    compare_logs("b2b");
    ready_delay = 0;

    // Both strobes low together: treated as a write only.
    @(negedge clk); slot_a = 8'h8A; slot_d_in = 8'h77;
    @(negedge clk); slot_iorq_n = 1'b0; slot_rd_n = 1'b0; slot_wr_n = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (slot_data_dir) bad = 1'b1;
    end
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
    drain("simul");
    check("simul_no_dir", {31'd0, bad}, 32'd0);
    exp_q.push_back('{1'b1, 2'd2, 8'h77});
    compare_logs("simul");

    // Strobe low for exactly one clock still produces one write.
    @(negedge clk); slot_a = 8'h8A; slot_d_in = 8'h99;
    @(negedge clk); slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    @(negedge clk); slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    repeat (6) @(negedge clk);
    drain("glitch");
    exp_q.push_back('{1'b1, 2'd2, 8'h99});
    compare_logs("glitch");

    // Reset while the bridge drives the slot data bus.
    rdata_delay = 2; rdata_val = 8'hC3;
    @(negedge clk); slot_a = 8'h8A;
    @(negedge clk); slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
    cnt = 0;
    while (!slot_data_dir && cnt < 100) begin @(negedge clk); cnt++; end
    check("rhold_reached", {31'd0, slot_data_dir}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rhold_rst_dir", {31'd0, slot_data_dir}, 32'd0);
    check("rhold_rst_valid", {31'd0, bus_valid}, 32'd0);
    check("rhold_rst_wait", {31'd0, slot_wait}, 32'd1);
    @(negedge clk); slot_iorq_n = 1'b1; slot_rd_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    obs_q.delete(); exp_q.delete();
    rdata_delay = 0;
    repeat (3) @(negedge clk);
    run_op("post_rst", 1'b1, 8'h8B, 8'hFF);
    drain("post_rst");
    compare_logs("post_rst");

    // Randomised traffic against the expected-transaction model.
    for (int i = 0; i < 40; i++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = IO_BASE + 8'($urandom_range(0, 3));
      else begin
        a = 8'($urandom_range(0, 255));
        while (a >= IO_BASE && a < IO_BASE + 8'd4) a = 8'($urandom_range(0, 255));
      end
      ready_delay = $urandom_range(0, 6);
      rdata_delay = $urandom_range(0, 6);
      run_op($sformatf("rand%0d", i), wr, a, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand");
    compare_logs("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msx_slot_io_bridge.md
Name: msx_slot_io_bridge

Overview:
- Front stage of the VDP cartridge. Converts asynchronous MSX Z80 slot I/O cycles (/IORQ, /RD, /WR, A[7:0], D[7:0]) into single-request transactions on the internal VDP bus, which runs on the 85.90908 MHz system clock.
- Decodes the 4-port VDP window, synchronises strobes, buffers one write, serves reads with slot data-bus steering, and drives slot_wait while the VDP is not ready or still initialising.

Parameters:
- IO_BASE, 8'h88, base I/O address of the 4-port window; bits [1:0] must be 0.
- SYNC_STAGES, 2, flip-flop stages on /IORQ, /RD, /WR; legal values 2 or 3.

Ports:
- clk  in  1  system clock, 85.90908 MHz.
- reset  in  1  asynchronous, active-high reset.
- init_busy  in  1  VDP/SDRAM initialisation in progress.
- slot_a  in  8  Z80 address bus, low byte.
- slot_d_in  in  8  slot data bus, input side.
- slot_d_out  out  8  slot data bus, output side.
- slot_data_dir  out  1  1 = cartridge drives slot_d; 0 = slot_d is input.
- slot_iorq_n  in  1  Z80 /IORQ.
- slot_rd_n  in  1  Z80 /RD.
- slot_wr_n  in  1  Z80 /WR.
- slot_wait  out  1  1 = request WAIT to the CPU.
- bus_address  out  2  port offset, A[1:0].
- bus_write  out  1  1 = write request, 0 = read request.
- bus_valid  out  1  request valid.
- bus_ready  in  1  VDP accepts the request in any cycle where bus_valid=1 and bus_ready=1.
- bus_wdata  out  8  write data.
- bus_rdata  in  8  read data.
- bus_rdata_en  in  1  one-cycle strobe marking bus_rdata valid.

Behaviour:
- Reset values:
  - slot_d_out=0, slot_data_dir=0.
  - slot_wait=1 while reset is high.
  - bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0.
  - State = IDLE.
- Synchronisation and decode:
  - iorq/rd/wr each pass through SYNC_STAGES flops. Call the outputs s_iorq, s_rd, s_wr (active-low).
  - hit = (slot_a[7:2] == IO_BASE[7:2]). slot_a and slot_d_in are sampled unsynchronised at the detect cycle; the Z80 holds them stable well before the strobes.
  - wr_start = s_iorq=0 and s_wr=0, while the same condition was false in the previous cycle.
  - rd_start = the same rule using s_rd.
- slot_wait = init_busy OR (state==RD_WAIT) OR (state==WR_REQ and a new hit start is pending). It is combinational from registered state plus init_busy.
- FSM:
  - IDLE:
    - wr_start and hit: latch bus_address=slot_a[1:0] and bus_wdata=slot_d_in; set bus_write=1, bus_valid=1; go to WR_REQ.
    - rd_start and hit: latch bus_address; set bus_write=0, bus_valid=1; go to RD_WAIT.
    - Non-hit starts are ignored and the state stays IDLE.
  - WR_REQ:
    - When bus_valid and bus_ready: clear bus_valid; go to END.
    - The CPU write cycle may already have ended. The write is buffered and the cycle is still completed.
  - RD_WAIT:
    - bus_valid clears on acceptance (valid and ready).
    - On bus_rdata_en: slot_d_out=bus_rdata, slot_data_dir=1; go to RD_HOLD.
    - bus_rdata_en arriving in the same cycle as acceptance is legal.
  - RD_HOLD:
    - Hold slot_data_dir=1 until s_rd=1 or s_iorq=1.
    - Then slot_data_dir=0 on the next edge; go to IDLE.
  - END: wait until s_iorq=1 AND s_wr=1 AND s_rd=1, then go to IDLE. This prevents a double issue for one cycle.
- Back-to-back writes:
  - A new hit start detected in WR_REQ is not dropped. slot_wait asserts, which stretches the CPU cycle.
  - Once the pending write is accepted, the FSM goes directly to the new request: latch the new address/data and skip END.
- Latency:
  - Sync to detect is SYNC_STAGES+1 clk.
  - Detect to bus_valid is 1 clk.
  - bus_rdata_en to slot_data_dir=1 is 1 clk.
- init_busy=1:
  - slot_wait=1.
  - Starts are still detected and queued normally; the VDP withholds bus_ready.
- Reset mid-operation returns immediately to the reset values: any pending request is discarded and slot_data_dir drops to 0 asynchronously.
- Simultaneous s_rd and s_wr low (illegal): the write takes priority and the read is ignored.
- Glitch rule: a strobe low for a single clk after sync still generates one start.

Test Plan:
- Reset released, init_busy=1 for 100 clk then 0 -> slot_wait=1 until 1 clk after init_busy falls; no bus_valid during this window.
- Z80-timed OUT (88h),5Ah with bus_ready tied 1 -> exactly one bus_valid pulse, bus_write=1, bus_address=0, bus_wdata=5Ah; no second pulse before /IORQ rises.
- OUT (89h),80h with bus_ready held 0 for 40 clk, followed immediately by OUT (89h),43h -> slot_wait=1 during the second cycle; the two writes are issued in order with data 80h then 43h.
- IN A,(89h) with bus_rdata=A5h and bus_rdata_en 10 clk after acceptance -> slot_wait=1 until data is ready; slot_d_out=A5h and slot_data_dir=1 until /RD rises; slot_data_dir=0 within SYNC_STAGES+2 clk.
- OUT (98h),11h and IN (8Ch) -> no bus_valid; slot_data_dir stays 0; slot_wait stays 0.
- reset asserted while in RD_HOLD -> slot_data_dir=0 and bus_valid=0 immediately; the next OUT (8Bh),FFh after release is handled normally.
